// File: rtl/alu_operand_entry_if.sv
// Bus between the operand-entry sequencer and its surroundings:
// slide switches, step button, ALU operands/result and display outputs.
interface alu_operand_entry_if;
  logic [31:0] sw;
  logic        btn;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] disp_data;
  logic [3:0]  flags;
  logic [1:0]  state;
  logic        done;

  modport master (
    input  sw, btn, alu_out, alu_flags,
    output a, b, op, disp_data, flags, state, done
  );

  modport slave (
    output sw, btn, alu_out, alu_flags,
    input  a, b, op, disp_data, flags, state, done
  );
endinterface

// File: rtl/alu_operand_entry.sv
// Debounced single-button sequencer that loads ALU operands and opcode from
// the slide switches, waits the ALU latency and captures result and flags.
//
// state   | meaning
// GET_A   | preview sw, press latches operand A
// GET_B   | preview sw, press latches operand B
// GET_OP  | preview sw, press latches opcode and starts EXEC
// EXEC    | ALU_LAT cycles, button ignored, last cycle captures result/flags
// SHOW    | show captured result, press returns to GET_A
module alu_operand_entry #(
  parameter int DEB_CYCLES = 16,
  parameter int ALU_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  alu_operand_entry_if.master        bus
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam int EW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] DEB_TC    = CW'(DEB_CYCLES - 1);
  localparam logic [EW-1:0] EXEC_LOAD = EW'(ALU_LAT - 1);

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SHOW   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          deb_q, deb_d;
  logic          deb_prev_q, deb_prev_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] exec_cnt_q, exec_cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   result_q, result_d;
  logic [3:0]    op_q, op_d;
  logic [3:0]    flags_q, flags_d;
  logic          press;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_GET_A;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      exec_cnt_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      op_q       <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      exec_cnt_q <= exec_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      op_q       <= op_d;
      flags_q    <= flags_d;
    end
  end

  always_comb begin
    s1_d       = bus.btn;
    s2_d       = s1_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    deb_prev_d = deb_q;
    press      = deb_q & ~deb_prev_q;
    // cnt only runs while the synchronized level disagrees with deb
    if (s2_q != deb_q) begin
      if (cnt_q == DEB_TC) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    state_d    = state_q;
    exec_cnt_d = exec_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    flags_d    = flags_q;
    done_d     = 1'b0;
    case (state_q)
      ST_GET_A: if (press) begin
        a_d     = bus.sw;
        state_d = ST_GET_B;
      end
      ST_GET_B: if (press) begin
        b_d     = bus.sw;
        state_d = ST_GET_OP;
      end
      ST_GET_OP: if (press) begin
        op_d       = bus.sw[3:0];
        exec_cnt_d = EXEC_LOAD;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_cnt_q == '0) begin
          result_d = bus.alu_out;
          flags_d  = bus.alu_flags;
          done_d   = 1'b1;
          state_d  = ST_SHOW;
        end else begin
          exec_cnt_d = exec_cnt_q - 1'b1;
        end
      end
      ST_SHOW: if (press) begin
        state_d = ST_GET_A;
      end
      default: state_d = ST_GET_A;
    endcase
  end

  always_comb begin
    bus.state     = 2'd0;
    bus.disp_data = bus.sw;
    case (state_q)
      ST_GET_B:  bus.state = 2'd1;
      ST_GET_OP: bus.state = 2'd2;
      ST_EXEC: begin
        bus.state     = 2'd2;
        bus.disp_data = result_q;
      end
      ST_SHOW: begin
        bus.state     = 2'd3;
        bus.disp_data = result_q;
      end
      default: ;
    endcase
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.op    = op_q;
  assign bus.flags = flags_q;
  assign bus.done  = done_q;

endmodule
